// File: rtl/alu_operand_stage.sv
// Operand-fetch stage in front of the ALU: 64 x 16-bit register file, pending-write scoreboard
// and a one-deep valid/ready output register. Optional macro FWD_WB_EN adds same-cycle writeback bypass.
module alu_operand_stage #(
   parameter int NREGS      = 64,
   parameter bit RESET_REGS = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [5:0]  in_d,
   input  logic [5:0]  in_s,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] alu_x,
   output logic [15:0] alu_y,
   output logic [3:0]  alu_op,
   output logic [5:0]  alu_d,
   input  logic        wb_en,
   input  logic [5:0]  wb_addr,
   input  logic [15:0] wb_data
);

   localparam logic [3:0] OP_ST   = 4'b1101;
   localparam logic [3:0] OP_JZSZ = 4'b1110;

   logic [15:0]      regs [NREGS];
   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] pending_next;
   logic [NREGS-1:0] wb_clear;
   logic [NREGS-1:0] hz_pending;
   logic [15:0]      x_operand;
   logic [15:0]      y_operand;
   logic             writes_d;
   logic             hz;
   logic             out_free;
   logic             accept;

   // Stores and conditional jumps never produce a register result.
   assign writes_d = (in_op != OP_ST) && (in_op != OP_JZSZ);

   always_comb begin
      wb_clear = '0;
      if (wb_en) begin
         wb_clear[wb_addr] = 1'b1;
      end
   end

`ifdef FWD_WB_EN
   // A writeback landing this cycle already satisfies the dependency and supplies the operand.
   assign hz_pending = pending & ~wb_clear;
   assign x_operand  = (wb_en && (wb_addr == in_s)) ? wb_data : regs[in_s];
   assign y_operand  = (wb_en && (wb_addr == in_d)) ? wb_data : regs[in_d];
`else
   assign hz_pending = pending;
   assign x_operand  = regs[in_s];
   assign y_operand  = regs[in_d];
`endif

   assign hz       = hz_pending[in_s] | hz_pending[in_d];
   assign out_free = ~out_valid | out_ready;
   assign in_ready = out_free & ~hz & ~reset;
   assign accept   = in_valid & in_ready;

   // A new pending mark for the accepted destination overrides a same-cycle writeback clear.
   always_comb begin
      pending_next = pending & ~wb_clear;
      if (accept && writes_d) begin
         pending_next[in_d] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= '0;
      end else begin
         pending <= pending_next;
      end
   end

   generate
      if (RESET_REGS) begin : g_regs_reset
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < NREGS; i++) begin
                  regs[i] <= '0;
               end
            end else if (wb_en) begin
               regs[wb_addr] <= wb_data;
            end
         end
      end else begin : g_regs_noreset
         // Contents survive reset, but a writeback coinciding with reset is still dropped.
         always_ff @(posedge clk) begin
            if (!reset && wb_en) begin
               regs[wb_addr] <= wb_data;
            end
         end
      end
   endgenerate

   // Output register: loads on accept, empties when consumed, otherwise holds its contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         alu_x     <= '0;
         alu_y     <= '0;
         alu_op    <= '0;
         alu_d     <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         alu_x     <= x_operand;
         alu_y     <= y_operand;
         alu_op    <= in_op;
         alu_d     <= in_d;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the register file and scoreboard.
module tb_alu_operand_stage;

`ifdef FWD_WB_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [5:0]  in_d;
   logic [5:0]  in_s;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] alu_x;
   logic [15:0] alu_y;
   logic [3:0]  alu_op;
   logic [5:0]  alu_d;
   logic        wb_en;
   logic [5:0]  wb_addr;
   logic [15:0] wb_data;

   always #5 clk = ~clk;

   alu_operand_stage dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_d      (in_d),
      .in_s      (in_s),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_x     (alu_x),
      .alu_y     (alu_y),
      .alu_op    (alu_op),
      .alu_d     (alu_d),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data)
   );

   int testsRun    = 0;
   int testsFailed = 0;

   logic [15:0] mRegs [64];
   bit          mPending [64];
   bit          mOutValid = 1'b0;
   logic [15:0] mX = '0;
   logic [15:0] mY = '0;
   logic [3:0]  mOp = '0;
   logic [5:0]  mD = '0;
   logic        lastReady;
   bit          lastAccept;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit modelWritesDest(input logic [3:0] op);
      return !(op == 4'b1101 || op == 4'b1110);
   endfunction

   // One clock of stimulus: drive, check in_ready, clock, advance the model, check the outputs.
   task automatic applyStimulus(input bit rst, input bit iv, input logic [3:0] op,
                                input logic [5:0] d, input logic [5:0] s, input bit ordy,
                                input bit we, input logic [5:0] wa, input logic [15:0] wd);
      bit          hzS;
      bit          hzD;
      bit          expReady;
      logic [15:0] opX;
      logic [15:0] opY;
      @(negedge clk);
      reset     = rst;
      in_valid  = iv;
      in_op     = op;
      in_d      = d;
      in_s      = s;
      out_ready = ordy;
      wb_en     = we;
      wb_addr   = wa;
      wb_data   = wd;
      hzS = mPending[s] && !(FWD && we && wa == s);
      hzD = mPending[d] && !(FWD && we && wa == d);
      expReady = (!mOutValid || ordy) && !hzS && !hzD && !rst;
      #1;
      lastReady = in_ready;
      checkOutput("in_ready", in_ready, expReady);
      @(posedge clk);
      lastAccept = 1'b0;
      if (rst) begin
         mOutValid = 1'b0;
         mX = '0; mY = '0; mOp = '0; mD = '0;
         for (int i = 0; i < 64; i++) begin
            mRegs[i]    = '0;
            mPending[i] = 1'b0;
         end
      end else begin
         lastAccept = iv && expReady;
         opX = (FWD && we && wa == s) ? wd : mRegs[s];
         opY = (FWD && we && wa == d) ? wd : mRegs[d];
         if (lastAccept) begin
            mOutValid = 1'b1;
            mX = opX; mY = opY; mOp = op; mD = d;
         end else if (ordy && mOutValid) begin
            mOutValid = 1'b0;
         end
         if (we) begin
            mRegs[wa]    = wd;
            mPending[wa] = 1'b0;
         end
         if (lastAccept && modelWritesDest(op)) begin
            mPending[d] = 1'b1;
         end
      end
      #1;
      checkOutput("out_valid", out_valid, mOutValid);
      checkOutput("alu_x", alu_x, mX);
      checkOutput("alu_y", alu_y, mY);
      checkOutput("alu_op", alu_op, mOp);
      checkOutput("alu_d", alu_d, mD);
   endtask

   initial begin
      int          waited;
      logic        savedReady;
      logic [5:0]  pendQ [$];
      bit          rr;
      bit          iv;
      bit          ordy;
      bit          we;
      logic [5:0]  wa;

      reset = 1'b1; in_valid = 1'b0; in_op = '0; in_d = '0; in_s = '0;
      out_ready = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;

      // Reset, load r1/r2, issue op 0011 d=1 s=2
      applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 1, 1, 5, 16'hdead);
      checkOutput("reset_valid", out_valid, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 16'h3f80);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 2, 16'h4040);
      applyStimulus(0, 1, 4'b0011, 1, 2, 1, 0, 0, 0);
      checkOutput("t1_valid", out_valid, 1);
      checkOutput("t1_x", alu_x, 16'h4040);
      checkOutput("t1_y", alu_y, 16'h3f80);
      checkOutput("t1_op", alu_op, 4'b0011);
      checkOutput("t1_d", alu_d, 1);
      applyStimulus(0, 1, 4'b0000, 1, 0, 1, 0, 0, 0);
      checkOutput("t1_pend1_stall", lastReady, 0);

      // Back-to-back dependency on r3
      applyStimulus(0, 1, 4'b0000, 3, 4, 1, 0, 0, 0);
      checkOutput("t2_first_accept", lastReady, 1);
      applyStimulus(0, 1, 4'b0000, 5, 3, 1, 0, 0, 0);
      applyStimulus(0, 1, 4'b0000, 5, 3, 1, 0, 0, 0);
      checkOutput("t2_stall", lastReady, 0);
      applyStimulus(0, 1, 4'b0000, 5, 3, 1, 1, 3, 16'h0007);
      checkOutput("t2_wb_cycle_ready", lastReady, FWD);
      waited = 0;
      while (!lastAccept && waited < 4) begin
         applyStimulus(0, 1, 4'b0000, 5, 3, 1, 0, 0, 0);
         waited++;
      end
      checkOutput("t2_extra_wait", waited, FWD ? 0 : 1);
      checkOutput("t2_alu_x", alu_x, 16'h0007);

      // Backpressure for 5 cycles, then release
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 1, 4'b0000, 9, 10, 0, 0, 0, 0);
         checkOutput("t3_hold_ready", lastReady, 0);
         checkOutput("t3_hold_x", alu_x, 16'h0007);
         checkOutput("t3_hold_d", alu_d, 5);
      end
      applyStimulus(0, 1, 4'b0000, 9, 10, 1, 0, 0, 0);
      checkOutput("t3_release_ready", lastReady, 1);
      checkOutput("t3_release_d", alu_d, 9);

      // st does not mark its d field pending
      applyStimulus(0, 1, 4'b1101, 6, 7, 1, 0, 0, 0);
      applyStimulus(0, 1, 4'b0000, 6, 6, 1, 0, 0, 0);
      checkOutput("t4_no_stall", lastReady, 1);

      // Reset mid-operation clears the held instruction and scoreboard
      applyStimulus(0, 1, 4'b0000, 3, 0, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 3, 16'hbeef);
      checkOutput("t5_valid", out_valid, 0);
      applyStimulus(0, 1, 4'b0000, 4, 3, 1, 0, 0, 0);
      checkOutput("t5_r3_ready", lastReady, 1);
      checkOutput("t5_r3_value", alu_x, 16'h0000);

      // Writeback of pending r8 in the same cycle as an instruction with d=8
      applyStimulus(0, 1, 4'b0000, 8, 0, 1, 0, 0, 0);
      applyStimulus(0, 1, 4'b0000, 8, 1, 1, 1, 8, 16'h1234);
      savedReady = lastReady;
      checkOutput("t6_same_cycle_ready", savedReady, FWD);
      applyStimulus(0, 1, 4'b0000, 2, 8, 1, 0, 0, 0);
      checkOutput("t6_pend8_kept", lastReady, !FWD);
      checkOutput("t6_r8_value", lastAccept ? alu_x : alu_y, 16'h1234);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rr   = ($urandom_range(0, 99) == 0);
         iv   = ($urandom_range(0, 9) < 7);
         ordy = ($urandom_range(0, 3) != 0);
         we   = ($urandom_range(0, 9) < 4);
         pendQ.delete();
         for (int i = 0; i < 64; i++) begin
            if (mPending[i]) pendQ.push_back(6'(i));
         end
         if (pendQ.size() > 0 && $urandom_range(0, 9) < 8) begin
            wa = pendQ[$urandom_range(0, pendQ.size() - 1)];
         end else begin
            wa = 6'($urandom_range(0, 15));
         end
         applyStimulus(rr, iv, 4'($urandom), 6'($urandom_range(0, 15)),
                       6'($urandom_range(0, 15)), ordy, we, wa, 16'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
